core_test_sequencer: RTL and testbench

CORE_TEST_SEQUENCER -- requirements
Module: core_test_sequencer

---
 rtl/core_tb_pkg.sv | 23 ++
 rtl/core_exp_table.sv | 50 +++++
 rtl/core_test_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_core_test_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_tb_pkg.sv
// Shared types and parameter defaults for the core test sequencer.
package core_tb_pkg;

  localparam int unsigned XLEN_DEF         = 32;
  localparam int unsigned NREGS_DEF        = 32;
  localparam int unsigned NCHK_DEF         = 8;
  localparam int unsigned RESET_CYCLES_DEF = 4;
  localparam bit          REQUIRE_HALT_DEF = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_CORE,
    ST_RUN,
    ST_READ,
    ST_CMP,
    ST_DONE
  } seq_state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_exp_table.sv
// Expectation table: NCHK (register, value) entries with per-slot valid bits.
module core_exp_table
  import core_tb_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned RW   = 5,
  parameter int unsigned NCHK = NCHK_DEF,
  parameter int unsigned IW   = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic            clr_i,
  input  logic [IW-1:0]   widx_i,
  input  logic [RW-1:0]   wreg_i,
  input  logic [XLEN-1:0] wval_i,
  input  logic [IW-1:0]   ridx_i,
  output logic            rvalid_o,
  output logic [RW-1:0]   rreg_o,
  output logic [XLEN-1:0] rval_o
);

  logic [NCHK-1:0] valid_q;
  logic [RW-1:0]   reg_q [NCHK];
  logic [XLEN-1:0] val_q [NCHK];
  logic            wr_ok;

  assign wr_ok = we_i && (32'(widx_i) < NCHK);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      valid_q <= '0;
    end else if (wr_ok) begin
      valid_q[widx_i] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk_i) begin
    if (wr_ok && !clr_i) begin
      reg_q[widx_i] <= wreg_i;
      val_q[widx_i] <= wval_i;
    end
  end

  assign rvalid_o = valid_q[ridx_i];
  assign rreg_o   = reg_q[ridx_i];
  assign rval_o   = val_q[ridx_i];

endmodule

// File: rtl/core_test_sequencer.sv
// Resets a core, lets it run until halt or a cycle limit, then compares
// selected register-file entries against a programmed expectation table.
module core_test_sequencer
  import core_tb_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEF,
  parameter int unsigned NREGS        = NREGS_DEF,
  parameter int unsigned NCHK         = NCHK_DEF,
  parameter int unsigned RESET_CYCLES = RESET_CYCLES_DEF,
  parameter bit          REQUIRE_HALT = REQUIRE_HALT_DEF,
  localparam int unsigned RW = clog2_min1(NREGS),
  localparam int unsigned CW = $clog2(NCHK + 1),
  localparam int unsigned IW = clog2_min1(NCHK)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [31:0]     max_cycles,
  input  logic            halt_i,
  output logic            core_reset_o,
  output logic            stall_o,
  input  logic            exp_we_i,
  input  logic [IW-1:0]   exp_idx_i,
  input  logic [RW-1:0]   exp_reg_i,
  input  logic [XLEN-1:0] exp_val_i,
  input  logic            exp_clr_i,
  output logic [RW-1:0]   rf_raddr_o,
  input  logic [XLEN-1:0] rf_rdata_i,
  output logic            mism_valid_o,
  output logic [RW-1:0]   mism_reg_o,
  output logic [XLEN-1:0] mism_exp_o,
  output logic [XLEN-1:0] mism_got_o,
  output logic            done_o,
  output logic            pass_o,
  output logic            timeout_o,
  output logic [CW-1:0]   fail_count_o,
  output logic [CW-1:0]   check_count_o
);

  seq_state_e      state_q, state_d;
  logic [31:0]     rst_cnt_q, rst_cnt_d;
  logic [31:0]     cyc_q, cyc_d;
  logic [31:0]     lim_q, lim_d;
  logic [IW-1:0]   slot_q, slot_d;
  logic [RW-1:0]   raddr_q, raddr_d;
  logic [CW-1:0]   fail_q, fail_d;
  logic [CW-1:0]   chk_q, chk_d;
  logic            timeout_q, timeout_d;
  logic            done_q, done_d;

  logic            tbl_we, tbl_clr;
  logic            rd_valid;
  logic [RW-1:0]   rd_reg;
  logic [XLEN-1:0] rd_val;
  logic [XLEN-1:0] got;
  logic            last_slot;

  core_exp_table #(
    .XLEN (XLEN),
    .RW   (RW),
    .NCHK (NCHK),
    .IW   (IW)
  ) u_table (
    .clk_i    (clk),
    .rst_i    (reset),
    .we_i     (tbl_we),
    .clr_i    (tbl_clr),
    .widx_i   (exp_idx_i),
    .wreg_i   (exp_reg_i),
    .wval_i   (exp_val_i),
    .ridx_i   (slot_q),
    .rvalid_o (rd_valid),
    .rreg_o   (rd_reg),
    .rval_o   (rd_val)
  );

  assign last_slot = (slot_q == IW'(NCHK - 1));

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    cyc_d        = cyc_q;
    lim_d        = lim_q;
    slot_d       = slot_q;
    raddr_d      = raddr_q;
    fail_d       = fail_q;
    chk_d        = chk_q;
    timeout_d    = timeout_q;
    done_d       = done_q;
    core_reset_o = 1'b0;
    stall_o      = 1'b0;
    tbl_we       = 1'b0;
    tbl_clr      = 1'b0;
    rf_raddr_o   = raddr_q;
    mism_valid_o = 1'b0;
    mism_reg_o   = '0;
    mism_exp_o   = '0;
    mism_got_o   = '0;
    got          = '0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        core_reset_o = (state_q == ST_IDLE);
        stall_o      = (state_q == ST_DONE);
        tbl_we       = exp_we_i;
        tbl_clr      = exp_clr_i;
        if (start) begin
          state_d   = ST_RST_CORE;
          rst_cnt_d = '0;
          fail_d    = '0;
          chk_d     = '0;
          timeout_d = 1'b0;
          done_d    = 1'b0;
          lim_d     = (max_cycles == '0) ? 32'd1 : max_cycles;
        end
      end
      ST_RST_CORE: begin
        core_reset_o = 1'b1;
        rst_cnt_d    = rst_cnt_q + 32'd1;
        if (rst_cnt_q == RESET_CYCLES - 1) begin
          state_d = ST_RUN;
          cyc_d   = '0;
        end
      end
      ST_RUN: begin
        cyc_d = cyc_q + 32'd1;
        // Halt is checked first so it wins over a coincident limit.
        if (halt_i) begin
          state_d   = ST_READ;
          timeout_d = 1'b0;
          slot_d    = '0;
        end else if (cyc_q == lim_q - 32'd1) begin
          state_d   = ST_READ;
          timeout_d = 1'b1;
          slot_d    = '0;
        end
      end
      ST_READ: begin
        stall_o = 1'b1;
        if (rd_valid) begin
          rf_raddr_o = rd_reg;
          raddr_d    = rd_reg;
          state_d    = ST_CMP;
        end else if (last_slot) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          slot_d = slot_q + IW'(1);
        end
      end
      ST_CMP: begin
        stall_o = 1'b1;
        got     = (raddr_q == '0) ? '0 : rf_rdata_i;
        chk_d   = chk_q + CW'(1);
        if (got !== rd_val) begin
          mism_valid_o = 1'b1;
          mism_reg_o   = raddr_q;
          mism_exp_o   = rd_val;
          mism_got_o   = got;
          fail_d       = fail_q + CW'(1);
        end
        if (last_slot) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_READ;
          slot_d  = slot_q + IW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rst_cnt_q <= '0;
      cyc_q     <= '0;
      lim_q     <= 32'd1;
      slot_q    <= '0;
      raddr_q   <= '0;
      fail_q    <= '0;
      chk_q     <= '0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      cyc_q     <= cyc_d;
      lim_q     <= lim_d;
      slot_q    <= slot_d;
      raddr_q   <= raddr_d;
      fail_q    <= fail_d;
      chk_q     <= chk_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
    end
  end

  assign done_o        = done_q;
  assign timeout_o     = timeout_q;
  assign fail_count_o  = fail_q;
  assign check_count_o = chk_q;
  assign pass_o        = done_q && (fail_q == '0) && !(REQUIRE_HALT && timeout_q);

endmodule

// File: tb/tb_core_test_sequencer.sv
// Bench: a timeline model predicts every output per cycle from the run rules.
module tb_core_test_sequencer;

  localparam int unsigned R  = 4;
  localparam int unsigned NC = 8;

  logic        clk = 1'b0;
  logic        reset, start, halt_i, exp_we_i, exp_clr_i;
  logic [31:0] max_cycles;
  logic [2:0]  exp_idx_i;
  logic [4:0]  exp_reg_i;
  logic [31:0] exp_val_i;
  logic [31:0] rf_rdata_i;
  logic        core_reset_o, stall_o, mism_valid_o, done_o, pass_o, timeout_o;
  logic [4:0]  rf_raddr_o, mism_reg_o;
  logic [31:0] mism_exp_o, mism_got_o;
  logic [3:0]  fail_count_o, check_count_o;

  core_test_sequencer #(
    .XLEN(32), .NREGS(32), .NCHK(NC), .RESET_CYCLES(R), .REQUIRE_HALT(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .max_cycles(max_cycles),
    .halt_i(halt_i), .core_reset_o(core_reset_o), .stall_o(stall_o),
    .exp_we_i(exp_we_i), .exp_idx_i(exp_idx_i), .exp_reg_i(exp_reg_i),
    .exp_val_i(exp_val_i), .exp_clr_i(exp_clr_i), .rf_raddr_o(rf_raddr_o),
    .rf_rdata_i(rf_rdata_i), .mism_valid_o(mism_valid_o), .mism_reg_o(mism_reg_o),
    .mism_exp_o(mism_exp_o), .mism_got_o(mism_got_o), .done_o(done_o),
    .pass_o(pass_o), .timeout_o(timeout_o), .fail_count_o(fail_count_o),
    .check_count_o(check_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic cr, st, dn, ps, to, mv, chk_ra;
    logic [31:0] ra, mreg, mexp, mgot, fc, cc;
  } exp_t;

  exp_t q[$];
  exp_t steady, ce, idle_rec;
  bit   chk_en = 0;
  int unsigned n_cmp = 0, n_bad = 0;

  logic        tv [NC];
  logic [4:0]  treg [NC];
  logic [31:0] tval [NC];
  logic [31:0] regs [32];
  logic [4:0]  ra_last = '0;

  logic        cap_mv;
  logic [31:0] cap_reg, cap_exp, cap_got;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input logic cr, st, dn, ps, to, chk_ra,
                              input logic [31:0] ra, fc, cc);
    exp_t e;
    e = '{cr: cr, st: st, dn: dn, ps: ps, to: to, mv: 1'b0, chk_ra: chk_ra,
          ra: ra, mreg: '0, mexp: '0, mgot: '0, fc: fc, cc: cc};
    return e;
  endfunction

  // Single compare process: one expected record per cycle, else the steady state.
  always @(negedge clk) begin
    if (chk_en) begin
      if (q.size() > 0) begin
        ce = q.pop_front();
        if (q.size() == 0) steady = ce;
      end else begin
        ce = steady;
      end
      chk("core_reset", core_reset_o, ce.cr);
      chk("stall", stall_o, ce.st);
      chk("done", done_o, ce.dn);
      chk("pass", pass_o, ce.ps);
      chk("timeout", timeout_o, ce.to);
      chk("fail_count", fail_count_o, ce.fc);
      chk("check_count", check_count_o, ce.cc);
      chk("mism_valid", mism_valid_o, ce.mv);
      if (ce.mv) begin
        chk("mism_reg", mism_reg_o, ce.mreg);
        chk("mism_exp", mism_exp_o, ce.mexp);
        chk("mism_got", mism_got_o, ce.mgot);
      end
      if (ce.chk_ra) chk("rf_raddr", rf_raddr_o, ce.ra);
    end
  end

  // Core register file model: read data appears the cycle after the address.
  task automatic tick();
    @(posedge clk);
    #1 rf_rdata_i = regs[ra_last];
    @(negedge clk);
    ra_last = rf_raddr_o;
    #1;
  endtask

  task automatic wr(input int unsigned idx, input logic [4:0] rg, input logic [31:0] v);
    exp_we_i = 1; exp_idx_i = 3'(idx); exp_reg_i = rg; exp_val_i = v;
    tv[idx] = 1; treg[idx] = rg; tval[idx] = v;
    tick();
    exp_we_i = 0;
  endtask

  task automatic clr_tbl(input bit with_we);
    exp_clr_i = 1; exp_we_i = with_we; exp_idx_i = 3'd5; exp_reg_i = 5'd7; exp_val_i = 32'd1;
    for (int i = 0; i < NC; i++) tv[i] = 0;
    tick();
    exp_clr_i = 0; exp_we_i = 0;
  endtask

  task automatic run(input int unsigned maxc, input int unsigned h, input int unsigned rst_at,
                     output int unsigned done_k, output int unsigned stall_k);
    int unsigned lim, len, total;
    logic tmo;
    logic [31:0] fc, cc, got;
    exp_t e;
    lim = (maxc == 0) ? 1 : maxc;
    tmo = !(h != 0 && h <= lim);
    len = tmo ? lim : h;
    fc = 0; cc = 0;
    for (int i = 0; i < R; i++) q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < len; i++) q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < NC; i++) begin
      if (tv[i]) begin
        q.push_back(mk(0, 1, 0, 0, tmo, 1, 32'(treg[i]), fc, cc));
        got = (treg[i] == 0) ? 32'd0 : regs[treg[i]];
        e = mk(0, 1, 0, 0, tmo, 1, 32'(treg[i]), fc, cc);
        if (got != tval[i]) begin
          e.mv = 1; e.mreg = 32'(treg[i]); e.mexp = tval[i]; e.mgot = got;
          fc++;
        end
        q.push_back(e);
        cc++;
      end else begin
        q.push_back(mk(0, 1, 0, 0, tmo, 0, 0, fc, cc));
      end
    end
    q.push_back(mk(0, 1, 1, (fc == 0) && !tmo, tmo, 0, 0, fc, cc));
    total = q.size();
    done_k = 0; stall_k = 0; cap_mv = 0;
    start = 1; max_cycles = maxc;
    tick();
    for (int unsigned k = 1; k <= total; k++) begin
      if (done_o && done_k == 0) done_k = k;
      if (stall_o && stall_k == 0) stall_k = k;
      if (mism_valid_o && !cap_mv) begin
        cap_mv = 1; cap_reg = 32'(mism_reg_o); cap_exp = mism_exp_o; cap_got = mism_got_o;
      end
      halt_i = (h != 0) && (k == R + h);
      if (k < total && $urandom_range(0, 5) == 0) begin
        start = 1; exp_we_i = 1; exp_clr_i = $urandom_range(0, 1);
        exp_idx_i = 3'($urandom); exp_reg_i = 5'($urandom); exp_val_i = $urandom;
        max_cycles = $urandom;
      end else begin
        start = 0; exp_we_i = 0; exp_clr_i = 0;
      end
      if (rst_at != 0 && k == rst_at) begin
        reset = 1; start = 0; exp_we_i = 0; exp_clr_i = 0; halt_i = 0;
        q.delete();
        steady = idle_rec;
        for (int i = 0; i < NC; i++) tv[i] = 0;
        tick();
        reset = 0;
        return;
      end
      tick();
    end
    start = 0; exp_we_i = 0; exp_clr_i = 0; halt_i = 0;
  endtask

  int unsigned dk, sk;

  initial begin
    idle_rec = mk(1, 0, 0, 0, 0, 1, 0, 0, 0);
    steady = idle_rec;
    reset = 1; start = 0; halt_i = 0; exp_we_i = 0; exp_clr_i = 0;
    max_cycles = 0; exp_idx_i = 0; exp_reg_i = 0; exp_val_i = 0; rf_rdata_i = 0;
    for (int i = 0; i < NC; i++) begin tv[i] = 0; treg[i] = 0; tval[i] = 0; end
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    tick();
    chk_en = 1;
    tick();
    reset = 0;
    tick(); tick();

    // Two matching slots, halt at RUN cycle 20
    wr(0, 5'd1, 32'd5); wr(1, 5'd2, 32'hA);
    regs[1] = 32'd5; regs[2] = 32'hA;
    run(100, 20, 0, dk, sk);
    tick();
    chk("t1_done_cycle", dk, 35);
    chk("t1_check_count", check_count_o, 2);
    chk("t1_pass", pass_o, 1);
    chk("t1_timeout", timeout_o, 0);

    // One mismatching slot
    wr(2, 5'd3, 32'h10); regs[3] = 32'h11;
    run(100, 5, 0, dk, sk);
    tick();
    chk("t2_done_cycle", dk, 21);
    chk("t2_mism_seen", cap_mv, 1);
    chk("t2_mism_reg", cap_reg, 3);
    chk("t2_mism_exp", cap_exp, 32'h10);
    chk("t2_mism_got", cap_got, 32'h11);
    chk("t2_fail_count", fail_count_o, 1);
    chk("t2_pass", pass_o, 0);

    // Cycle limit without halt
    regs[3] = 32'h10;
    run(50, 0, 0, dk, sk);
    tick();
    chk("t3_first_stall", sk, 55);
    chk("t3_timeout", timeout_o, 1);
    chk("t3_pass", pass_o, 0);

    // Halt coincident with the limit
    run(50, 50, 0, dk, sk);
    tick();
    chk("t4_first_stall", sk, 55);
    chk("t4_timeout", timeout_o, 0);
    chk("t4_pass", pass_o, 1);

    // Register 0 always reads as zero
    clr_tbl(0);
    wr(4, 5'd0, 32'd0); regs[0] = 32'hDEADBEEF;
    run(10, 3, 0, dk, sk);
    tick();
    chk("t5_pass", pass_o, 1);
    chk("t5_check_count", check_count_o, 1);

    // Clear beats write; max_cycles=0 runs one cycle
    clr_tbl(1);
    run(0, 0, 0, dk, sk);
    tick();
    chk("t6_done_cycle", dk, 14);
    chk("t6_check_count", check_count_o, 0);
    chk("t6_timeout", timeout_o, 1);

    // Reset during CMP, then an empty-table run
    wr(0, 5'd1, 32'd5);
    run(10, 4, R + 4 + 2, dk, sk);
    chk("t7_core_reset", core_reset_o, 1);
    chk("t7_done", done_o, 0);
    tick();
    run(10, 2, 0, dk, sk);
    tick();
    chk("t7_done_cycle", dk, 15);
    chk("t7_check_count", check_count_o, 0);
    chk("t7_pass", pass_o, 1);

    // Randomized runs
    for (int it = 0; it < 30; it++) begin
      int unsigned nw, idx, mc, hh;
      if ($urandom_range(0, 3) == 0) clr_tbl(0);
      nw = $urandom_range(1, 4);
      for (int j = 0; j < nw; j++) begin
        idx = $urandom_range(0, NC - 1);
        wr(idx, 5'($urandom), $urandom_range(0, 3));
      end
      for (int i = 0; i < 32; i++) regs[i] = $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0) regs[0] = 32'hDEADBEEF;
      mc = $urandom_range(0, 30);
      hh = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 35);
      run(mc, hh, 0, dk, sk);
      tick();
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
